// File: rtl/text_ram_arbiter_pkg.sv
// ============================================================================
// vga_text_pkg : shared constants, FSM state and write-entry type
// Rev 1.0
// ============================================================================
`default_nettype none

package vga_text_pkg;

   localparam int COLS   = 40;
   localparam int ROWS   = 30;
   localparam int CELLS  = COLS * ROWS;
   localparam int ADDR_W = 11;
   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] BLANK_CHAR = 8'h20;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } arb_state_t;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_entry_t;

endpackage

`default_nettype wire

// File: rtl/text_ram_arbiter_if.sv
// ============================================================================
// text_ram_arbiter_if : video read, calculator write, clear and RAM signals
// Rev 1.0
// ============================================================================
`default_nettype none

interface text_ram_arbiter_if
   import vga_text_pkg::*;
#(
   parameter int AW = ADDR_W,
   parameter int DW = DATA_W
);
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [DW-1:0] rd_data;
   logic          rd_valid;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          clear_req;
   logic          busy;
   logic          clear_done;
   logic          oob_drop;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;

   modport slave (
      input  rd_en, rd_addr, wr_valid, wr_addr, wr_data, clear_req, ram_rdata,
      output rd_data, rd_valid, wr_ready, busy, clear_done, oob_drop,
             ram_addr, ram_we, ram_wdata
   );

   modport master (
      output rd_en, rd_addr, wr_valid, wr_addr, wr_data, clear_req, ram_rdata,
      input  rd_data, rd_valid, wr_ready, busy, clear_done, oob_drop,
             ram_addr, ram_we, ram_wdata
   );

endinterface

`default_nettype wire

// File: rtl/text_ram_arbiter_fifo.sv
// ============================================================================
// char_wr_fifo : small synchronous FIFO of character write entries
// Rev 1.0
// ============================================================================
`default_nettype none

module char_wr_fifo
   import vga_text_pkg::*;
#(
   parameter int DEPTH = 4
)(
   input  wire logic                     clk,
   input  wire logic                     rst,
   input  wire logic                     i_push,
   input  wire wr_entry_t                i_data,
   input  wire logic                     i_pop,
   output wr_entry_t                     o_data,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(DEPTH):0]        o_count
);

   localparam int PW = $clog2(DEPTH);

   wr_entry_t     r_mem [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [PW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == (PW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_data    = r_mem[r_rptr];
   // A full FIFO refuses a push even when a pop frees a slot this cycle.
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wptr] <= i_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + 1'b1;
         if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/text_ram_arbiter.sv
// ============================================================================
// text_ram_arbiter : shares the character RAM between video reads, queued
// calculator writes and a whole-screen clear.            Rev 1.0
// ============================================================================
`default_nettype none

module text_ram_arbiter
   import vga_text_pkg::*;
#(
   parameter int              COLS       = vga_text_pkg::COLS,
   parameter int              ROWS       = vga_text_pkg::ROWS,
   parameter int              AW         = vga_text_pkg::ADDR_W,
   parameter int              DW         = vga_text_pkg::DATA_W,
   parameter int              FIFO_DEPTH = 4,
   parameter logic [DW-1:0]   BLANK_CHAR = vga_text_pkg::BLANK_CHAR
)(
   input wire logic           clk,
   input wire logic           reset,
   text_ram_arbiter_if.slave  bus
);

   localparam int             CW          = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]    c_cells     = (AW+1)'(COLS * ROWS);
   localparam logic [AW-1:0]  c_last_cell = AW'(COLS * ROWS - 1);
   localparam logic [CW:0]    c_depth     = (CW+1)'(FIFO_DEPTH);

   arb_state_t    r_state;
   arb_state_t    w_state_nxt;
   logic [AW-1:0] r_clr_addr;
   logic [AW-1:0] w_clr_addr_nxt;
   logic          r_rd_valid;
   logic          r_clear_done;
   logic          w_clear_done_nxt;
   logic          r_oob_drop;
   logic          w_oob_set;

   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_empty;
   logic [CW:0]   w_count;
   wr_entry_t     w_push_entry;
   wr_entry_t     w_head;

   logic [AW-1:0] w_ram_addr;
   logic          w_ram_we;
   logic [DW-1:0] w_ram_wdata;

   assign w_push_entry = '{addr: bus.wr_addr, data: bus.wr_data};
   assign w_push       = bus.wr_valid && !w_full;

   char_wr_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (w_push),
      .i_data  (w_push_entry),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_clr_addr   <= '0;
         r_rd_valid   <= 1'b0;
         r_clear_done <= 1'b0;
         r_oob_drop   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_clr_addr   <= w_clr_addr_nxt;
         r_rd_valid   <= bus.rd_en;
         r_clear_done <= w_clear_done_nxt;
         if (w_oob_set) r_oob_drop <= 1'b1;
      end
   end

   // Video read owns the port unconditionally; clear and drain only use idle slots.
   always_comb begin
      w_state_nxt      = r_state;
      w_clr_addr_nxt   = r_clr_addr;
      w_clear_done_nxt = 1'b0;
      w_oob_set        = 1'b0;
      w_pop            = 1'b0;
      w_ram_addr       = '0;
      w_ram_we         = 1'b0;
      w_ram_wdata      = '0;

      if (bus.rd_en) begin
         w_ram_addr = bus.rd_addr;
      end else if (r_state == CLEAR) begin
         w_ram_addr  = r_clr_addr;
         w_ram_we    = 1'b1;
         w_ram_wdata = BLANK_CHAR;
         if (r_clr_addr == c_last_cell) begin
            w_state_nxt      = IDLE;
            w_clr_addr_nxt   = '0;
            w_clear_done_nxt = 1'b1;
         end else begin
            w_clr_addr_nxt = r_clr_addr + 1'b1;
         end
      end else if (!w_empty) begin
         w_pop = 1'b1;
         if ({1'b0, w_head.addr} < c_cells) begin
            w_ram_addr  = w_head.addr;
            w_ram_we    = 1'b1;
            w_ram_wdata = w_head.data;
         end else begin
            w_oob_set = 1'b1;
         end
      end

      if (r_state == IDLE && bus.clear_req) begin
         w_state_nxt    = CLEAR;
         w_clr_addr_nxt = '0;
      end
   end

   assign bus.rd_data    = bus.ram_rdata;
   assign bus.rd_valid   = r_rd_valid;
   assign bus.wr_ready   = (w_count < c_depth);
   assign bus.busy       = (r_state == CLEAR);
   assign bus.clear_done = r_clear_done;
   assign bus.oob_drop   = r_oob_drop;
   assign bus.ram_addr   = w_ram_addr;
   assign bus.ram_we     = w_ram_we;
   assign bus.ram_wdata  = w_ram_wdata;

endmodule

`default_nettype wire

// File: tb/tb_text_ram_arbiter.sv
// ============================================================================
// tb_text_ram_arbiter : directed vectors plus clear / reset sequences
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_text_ram_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   n_total = 0;
   int   n_bad   = 0;

   always #5 clk = ~clk;

   text_ram_arbiter_if #(.AW(11), .DW(8)) bus();

   text_ram_arbiter #(
      .COLS       (40),
      .ROWS       (30),
      .AW         (11),
      .DW         (8),
      .FIFO_DEPTH (4),
      .BLANK_CHAR (8'h20)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   // Character RAM model: preset to addr^A5, synchronous read, old data on collision.
   logic [7:0] ram [2048];
   logic [7:0] r_q;
   bit         ram_init = 1'b0;
   assign bus.ram_rdata = r_q;

   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 2048; i++) ram[i] = 8'(i) ^ 8'hA5;
         ram_init = 1'b1;
      end
      r_q <= ram[bus.ram_addr];
      if (bus.ram_we) ram[bus.ram_addr] = bus.ram_wdata;
   end

   typedef struct {
      logic        rd_en;
      logic [10:0] rd_addr;
      logic        wv;
      logic [10:0] wa;
      logic [7:0]  wd;
      logic        e_we;
      logic [10:0] e_addr;
      logic [7:0]  e_wdata;
      logic        e_ready;
      logic        e_rdv;
      logic        chk_rd;
      logic [7:0]  e_rd;
      logic        e_oob;
   } vec_t;

   localparam int NV = 21;
   vec_t vecs [NV];

   function automatic vec_t mk(bit re, int ra, bit wv, int wa, int wd, bit ewe, int ea,
                               int ewd, bit erdy, bit ervd, bit crd, int erd, bit eoob);
      vec_t v;
      v.rd_en = re;    v.rd_addr = 11'(ra);
      v.wv    = wv;    v.wa      = 11'(wa);   v.wd = 8'(wd);
      v.e_we  = ewe;   v.e_addr  = 11'(ea);   v.e_wdata = 8'(ewd);
      v.e_ready = erdy; v.e_rdv  = ervd;
      v.chk_rd = crd;  v.e_rd    = 8'(erd);   v.e_oob = eoob;
      return v;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic read_chk(int a, logic [7:0] e);
      bus.rd_en   = 1'b1;
      bus.rd_addr = 11'(a);
      #2;
      tick();
      bus.rd_en = 1'b0;
      #2;
      chk($sformatf("rd%0d_valid", a), bus.rd_valid, 1);
      chk($sformatf("rd%0d_data", a), bus.rd_data, e);
      tick();
   endtask

   function automatic int exp_clear_cycles();
      int d = 0;
      int w = 0;
      while (w < 1200) begin
         if (d % 97 != 50) w++;
         d++;
      end
      return d;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nwr, nbad_ord, ndone, done_cyc, nbusy, nrdwe, entry_cnt, dur;
      bit entry_after, found;

      //        re ra   wv wa   wd    we ea   ewd   rdy rdv crd erd   oob
      vecs[0]  = mk(0, 0,   0, 0,    0,    0, 0,   0,    1, 0, 0, 0,    0);
      vecs[1]  = mk(0, 0,   1, 5,    'h41, 0, 0,   0,    1, 0, 0, 0,    0);
      vecs[2]  = mk(0, 0,   0, 0,    0,    1, 5,   'h41, 1, 0, 0, 0,    0);
      vecs[3]  = mk(0, 0,   0, 0,    0,    0, 0,   0,    1, 0, 0, 0,    0);
      vecs[4]  = mk(1, 10,  1, 100,  'h01, 0, 10,  0,    1, 0, 0, 0,    0);
      vecs[5]  = mk(1, 11,  1, 101,  'h02, 0, 11,  0,    1, 1, 1, 'hAF, 0);
      vecs[6]  = mk(1, 12,  1, 102,  'h03, 0, 12,  0,    1, 1, 1, 'hAE, 0);
      vecs[7]  = mk(1, 13,  1, 103,  'h04, 0, 13,  0,    1, 1, 1, 'hA9, 0);
      vecs[8]  = mk(1, 14,  1, 104,  'h05, 0, 14,  0,    0, 1, 1, 'hA8, 0);
      vecs[9]  = mk(1, 15,  1, 104,  'h05, 0, 15,  0,    0, 1, 1, 'hAB, 0);
      vecs[10] = mk(0, 0,   1, 104,  'h05, 1, 100, 'h01, 0, 1, 1, 'hAA, 0);
      vecs[11] = mk(0, 0,   0, 0,    0,    1, 101, 'h02, 1, 0, 0, 0,    0);
      vecs[12] = mk(0, 0,   0, 0,    0,    1, 102, 'h03, 1, 0, 0, 0,    0);
      vecs[13] = mk(0, 0,   0, 0,    0,    1, 103, 'h04, 1, 0, 0, 0,    0);
      vecs[14] = mk(0, 0,   0, 0,    0,    0, 0,   0,    1, 0, 0, 0,    0);
      vecs[15] = mk(0, 0,   1, 1200, 'h77, 0, 0,   0,    1, 0, 0, 0,    0);
      vecs[16] = mk(0, 0,   0, 0,    0,    0, 0,   0,    1, 0, 0, 0,    0);
      vecs[17] = mk(0, 0,   0, 0,    0,    0, 0,   0,    1, 0, 0, 0,    1);
      vecs[18] = mk(1, 5,   0, 0,    0,    0, 5,   0,    1, 0, 0, 0,    1);
      vecs[19] = mk(1, 100, 0, 0,    0,    0, 100, 0,    1, 1, 1, 'h41, 1);
      vecs[20] = mk(0, 0,   0, 0,    0,    0, 0,   0,    1, 1, 1, 'h01, 1);

      reset         = 1'b1;
      bus.rd_en     = 1'b0;
      bus.rd_addr   = '0;
      bus.wr_valid  = 1'b0;
      bus.wr_addr   = '0;
      bus.wr_data   = '0;
      bus.clear_req = 1'b0;
      repeat (3) tick();
      #2;
      chk("rst_rd_valid",   bus.rd_valid,   0);
      chk("rst_busy",       bus.busy,       0);
      chk("rst_clear_done", bus.clear_done, 0);
      chk("rst_oob_drop",   bus.oob_drop,   0);
      chk("rst_ram_we",     bus.ram_we,     0);
      chk("rst_wr_ready",   bus.wr_ready,   1);
      chk("rst_ram_addr",   bus.ram_addr,   0);
      chk("rst_ram_wdata",  bus.ram_wdata,  0);
      chk("rst_rd_data",    bus.rd_data,    r_q);
      reset = 1'b0;
      tick();

      for (int i = 0; i < NV; i++) begin
         bus.rd_en    = vecs[i].rd_en;
         bus.rd_addr  = vecs[i].rd_addr;
         bus.wr_valid = vecs[i].wv;
         bus.wr_addr  = vecs[i].wa;
         bus.wr_data  = vecs[i].wd;
         #2;
         chk($sformatf("v%0d_ram_we", i),    bus.ram_we,    vecs[i].e_we);
         chk($sformatf("v%0d_ram_addr", i),  bus.ram_addr,  vecs[i].e_addr);
         chk($sformatf("v%0d_ram_wdata", i), bus.ram_wdata, vecs[i].e_wdata);
         chk($sformatf("v%0d_wr_ready", i),  bus.wr_ready,  vecs[i].e_ready);
         chk($sformatf("v%0d_rd_valid", i),  bus.rd_valid,  vecs[i].e_rdv);
         chk($sformatf("v%0d_oob_drop", i),  bus.oob_drop,  vecs[i].e_oob);
         if (vecs[i].chk_rd) chk($sformatf("v%0d_rd_data", i), bus.rd_data, vecs[i].e_rd);
         tick();
      end
      bus.rd_en    = 1'b0;
      bus.wr_valid = 1'b0;

      // Screen clear with interleaved video reads, a queued write and a repeat request.
      bus.clear_req = 1'b1;
      #2;
      chk("clr_pulse_busy", bus.busy, 0);
      tick();
      bus.clear_req = 1'b0;
      dur = exp_clear_cycles();
      nwr = 0; nbad_ord = 0; ndone = 0; done_cyc = -1; nbusy = 0; nrdwe = 0;
      entry_cnt = 0; entry_after = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bus.rd_en     = (cyc % 97 == 50);
         bus.rd_addr   = 11'(cyc);
         bus.clear_req = (cyc == 300);
         bus.wr_valid  = (cyc == 5);
         bus.wr_addr   = 11'd7;
         bus.wr_data   = 8'h99;
         #2;
         if (bus.busy) nbusy++;
         if (bus.clear_done) begin
            ndone++;
            done_cyc = cyc;
         end
         if (bus.ram_we) begin
            if (bus.rd_en) nrdwe++;
            if (bus.ram_addr == 11'd7 && bus.ram_wdata == 8'h99) begin
               entry_cnt++;
               entry_after = (nwr == 1200);
            end else begin
               if (bus.ram_addr != 11'(nwr) || bus.ram_wdata != 8'h20) nbad_ord++;
               nwr++;
            end
         end
         tick();
         if (ndone > 0 && cyc >= done_cyc + 3) break;
      end
      bus.rd_en     = 1'b0;
      bus.clear_req = 1'b0;
      bus.wr_valid  = 1'b0;
      chk("clr_write_count",    nwr,         1200);
      chk("clr_write_order",    nbad_ord,    0);
      chk("clr_busy_cycles",    nbusy,       dur);
      chk("clr_done_cycle",     done_cyc,    dur);
      chk("clr_done_pulses",    ndone,       1);
      chk("clr_read_collision", nrdwe,       0);
      chk("queued_write_count", entry_cnt,   1);
      chk("queued_after_clear", entry_after, 1);

      read_chk(7,    8'h99);
      read_chk(8,    8'h20);
      read_chk(0,    8'h20);
      read_chk(1199, 8'h20);

      // Reset in the middle of a clear with an entry waiting in the FIFO.
      bus.clear_req = 1'b1;
      bus.wr_valid  = 1'b1;
      bus.wr_addr   = 11'd9;
      bus.wr_data   = 8'h33;
      #2;
      tick();
      bus.clear_req = 1'b0;
      bus.wr_valid  = 1'b0;
      found = 0;
      for (int c = 0; c < 2000 && !found; c++) begin
         #2;
         if (bus.ram_we && bus.ram_addr == 11'd600) found = 1;
         else tick();
      end
      chk("reach_addr_600",    found,        1);
      chk("pre_reset_busy",    bus.busy,     1);
      chk("pre_reset_oob",     bus.oob_drop, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #2;
      chk("post_reset_busy",   bus.busy,       0);
      chk("post_reset_oob",    bus.oob_drop,   0);
      chk("post_reset_ready",  bus.wr_ready,   1);
      chk("post_reset_we",     bus.ram_we,     0);
      chk("post_reset_done",   bus.clear_done, 0);
      tick();
      #2;
      chk("post_reset_fifo_empty", bus.ram_we, 0);
      bus.clear_req = 1'b1;
      tick();
      bus.clear_req = 1'b0;
      #2;
      chk("restart_clr_we",    bus.ram_we,    1);
      chk("restart_clr_addr",  bus.ram_addr,  0);
      chk("restart_clr_wdata", bus.ram_wdata, 8'h20);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
